// File: rtl/framebuffer_arbiter.sv
// Shares the framebuffer RAM port between scan-side pixel-pair fetches (strict priority) and a level-held write requester.
// Optional build macro FB_ARB_OVERRUN_EN enables the saturating dropped-edge counter on overrun_count.
module framebuffer_arbiter #(
  parameter int RAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic [3:0]  row_address,
  input  logic [5:0]  column_address,
  output logic [15:0] pixel_rgb565_top,
  output logic [15:0] pixel_rgb565_bottom,
  output logic        fetch_done,
  input  logic        wr_req,
  input  logic [10:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [10:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_ce,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic [7:0]  overrun_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_TOP = 2'd1,
    FETCH_BOT = 2'd2,
    WRITE     = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_fetch_start_d;
  logic        r_pending;
  logic [3:0]  r_row;
  logic [5:0]  r_col;
  logic [2:0]  r_cnt;
  logic [15:0] r_top_stage;
  logic [15:0] r_pixel_top;
  logic [15:0] r_pixel_bottom;
  logic        r_fetch_done;
  logic        w_edge;
  logic        w_start;
  logic        w_cnt_hit;

  assign w_edge    = fetch_start & ~r_fetch_start_d;
  assign w_cnt_hit = (r_cnt == LAT);

  always_ff @(posedge clk_in) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Write handshake: wr_req is a level held by the requester; wr_ack pulses for
  // exactly the one cycle the write is on the RAM port, after which wr_req may drop.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    ram_addr     = 11'd0;
    ram_wdata    = 16'd0;
    ram_ce       = 1'b0;
    ram_we       = 1'b0;
    wr_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge || r_pending) begin
          w_state_next = FETCH_TOP;
          w_start      = 1'b1;
        end else if (wr_req) begin
          w_state_next = WRITE;
        end
      end
      FETCH_TOP: begin
        ram_addr = {1'b0, r_row, ~r_col};
        ram_ce   = 1'b1;
        if (w_cnt_hit) w_state_next = FETCH_BOT;
      end
      FETCH_BOT: begin
        ram_addr = {1'b1, r_row, ~r_col};
        ram_ce   = 1'b1;
        if (w_cnt_hit) w_state_next = IDLE;
      end
      WRITE: begin
        ram_addr     = wr_addr;
        ram_wdata    = wr_data;
        ram_ce       = 1'b1;
        ram_we       = 1'b1;
        wr_ack       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Top pixel is staged so both visible pixel registers change together with fetch_done.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_fetch_start_d <= 1'b0;
      r_pending       <= 1'b0;
      r_row           <= 4'd0;
      r_col           <= 6'd0;
      r_cnt           <= 3'd0;
      r_top_stage     <= 16'd0;
      r_pixel_top     <= 16'd0;
      r_pixel_bottom  <= 16'd0;
      r_fetch_done    <= 1'b0;
    end else begin
      r_fetch_start_d <= fetch_start;
      r_fetch_done    <= 1'b0;
      if (w_start)                         r_pending <= 1'b0;
      else if (w_edge && r_state != IDLE)  r_pending <= 1'b1;
      if (w_start) begin
        r_row <= row_address;
        r_col <= column_address;
        r_cnt <= 3'd0;
      end else if (r_state == FETCH_TOP || r_state == FETCH_BOT) begin
        if (w_cnt_hit) begin
          r_cnt <= 3'd0;
          if (r_state == FETCH_TOP) begin
            r_top_stage <= ram_rdata;
          end else begin
            r_pixel_top    <= r_top_stage;
            r_pixel_bottom <= ram_rdata;
            r_fetch_done   <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  assign pixel_rgb565_top    = r_pixel_top;
  assign pixel_rgb565_bottom = r_pixel_bottom;
  assign fetch_done          = r_fetch_done;

`ifdef FB_ARB_OVERRUN_EN
  logic [7:0] r_overrun;
  // An edge arriving while one is already pending is dropped.
  always_ff @(posedge clk_in) begin
    if (reset)                                         r_overrun <= 8'd0;
    else if (w_edge && r_pending && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
  end
  assign overrun_count = r_overrun;
`else
  assign overrun_count = 8'd0;
`endif

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Sequences and shares the single read/write port of the framebuffer RAM between two requesters: the scan-side pixel fetch (two reads per pixel clock, top then bottom half) and a write requester (e.g. UART frame loader). Sits between `matrix_scan`/`clock_divider` and `framebuffer` on `clk_root`. It replaces ad-hoc load-counter sequencing with a state machine that gives fetches strict priority and bounds write latency.

## Interface
Parameters:
- `RAM_LATENCY`, 2, cycles from address presented (with `ram_ce` high) to valid `ram_rdata`; legal 1..7.

Ports:
- `clk_in`  in  1  clock; one clock domain (`clk_root`).
- `reset`  in  1  synchronous, active-high reset.
- `fetch_start`  in  1  fetch request; a rising edge (sampled on `clk_in`) requests one pixel-pair fetch.
- `row_address`  in  4  row of the pixel pair, sampled when the fetch begins.
- `column_address`  in  6  column, sampled when the fetch begins.
- `pixel_rgb565_top`  out  16  last fetched top-half pixel.
- `pixel_rgb565_bottom`  out  16  last fetched bottom-half pixel.
- `fetch_done`  out  1  one-cycle pulse; both pixel registers updated.
- `wr_req`  in  1  write request; level, held until `wr_ack`.
- `wr_addr`  in  11  write address.
- `wr_data`  in  16  write data.
- `wr_ack`  out  1  one-cycle pulse; write performed this cycle.
- `ram_addr`  out  11  RAM address.
- `ram_wdata`  out  16  RAM write data.
- `ram_ce`  out  1  RAM clock enable.
- `ram_we`  out  1  RAM write enable.
- `ram_rdata`  in  16  RAM read data.
- `overrun_count`  out  8  saturating count of dropped fetch edges (see Configuration).

## Operation
- Edge detect: `edge = fetch_start & ~fetch_start_d`; `fetch_start_d` registered, reset 0.
- `pending` flag: set by `edge` when state is not IDLE; cleared when a fetch starts from IDLE.
- States: IDLE, FETCH_TOP, FETCH_BOT, WRITE.
- IDLE: if `edge | pending` -> FETCH_TOP, latch `row_address`/`column_address`, `cnt<=0`; else if `wr_req` -> WRITE; else stay. Fetch wins over simultaneous `wr_req`.
- FETCH_TOP: `ram_addr = {1'b0, row, ~col}`, `ram_ce=1`, `ram_we=0`; `cnt` increments; at `cnt==RAM_LATENCY` capture `ram_rdata` into top, `cnt<=0`, -> FETCH_BOT.
- FETCH_BOT: `ram_addr = {1'b1, row, ~col}`, same counting; at `cnt==RAM_LATENCY` capture into bottom, set `fetch_done` (registered) -> IDLE.
- WRITE: `ram_addr=wr_addr`, `ram_wdata=wr_data`, `ram_ce=1`, `ram_we=1`, `wr_ack=1` (decoded from state) -> IDLE unconditionally.
- IDLE: `ram_ce=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
- Edge while `pending` already set: dropped (overrun).
- Pixel registers hold between fetches; never partially updated with a visible `fetch_done`.

## Timing
- Reset values: state IDLE, `pixel_rgb565_top/bottom=0`, `fetch_done=0`, `wr_ack=0`, `ram_ce=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `pending=0`, `overrun_count=0`.
- Fetch from IDLE: `edge` true at clock edge k -> `fetch_done` high for the cycle after edge k+2·(RAM_LATENCY+1); default 6 edges, i.e. pulse after edge k+6.
- Write: serviced no later than the cycle after an in-progress fetch ends; max throughput one write per 2 cycles (IDLE between).
- Worst-case fetch start latency: 1 cycle (a WRITE in progress).
- Reset mid-fetch or mid-write: next cycle outputs at reset values; no `fetch_done`/`wr_ack`; interrupted write counts as not performed.

## Configuration
- `FB_ARB_OVERRUN_EN` defined: `overrun_count` increments (saturating at 255) on each dropped edge; cleared only by `reset`.
- Undefined: no counter logic; `overrun_count` tied to 0; dropped edges still dropped.

## Test plan
- Reset, RAM model word `{0,row=3,~col=5}`=0x1234, `{1,3,~5}`=0xABCD; edge with row=3,col=5 -> after 6 edges `fetch_done` pulses, top=0x1234, bottom=0xABCD.
- `wr_req` with addr 0x100, data 0xBEEF in IDLE -> WRITE next cycle, `ram_we=1`, `wr_ack` one cycle; readback via fetch returns 0xBEEF.
- `wr_req` and `edge` same cycle -> fetch first, `wr_ack` the cycle after `fetch_done` state returns to IDLE +1.
- Edge during FETCH_BOT -> `pending`, second fetch starts immediately after IDLE; third edge before it starts -> `overrun_count`=1 (0 without `FB_ARB_OVERRUN_EN`).
- `reset` asserted in FETCH_TOP cnt=1 -> next cycle all outputs at reset values, no `fetch_done`.
- `RAM_LATENCY=1` build -> `fetch_done` 4 edges after start edge, correct data.
